// File: rtl/crc_pkg.sv
// Shared constants for the streaming CRC engine: mode encodings, polynomials,
// init values and FSM states.
package crc_pkg;

    localparam int unsigned CRC_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] CRC_MODE_8     = 3'b000;
    localparam logic [MODE_W-1:0] CRC_MODE_CCITT = 3'b001;
    localparam logic [MODE_W-1:0] CRC_MODE_16    = 3'b010;

    localparam logic [BYTE_W-1:0] POLY_8     = 8'h07;
    localparam logic [CRC_W-1:0]  POLY_CCITT = 16'h1021;
    localparam logic [CRC_W-1:0]  POLY_16    = 16'h8005;

    localparam logic [CRC_W-1:0] INIT_8     = 16'h0000;
    localparam logic [CRC_W-1:0] INIT_CCITT = 16'hFFFF;
    localparam logic [CRC_W-1:0] INIT_16    = 16'h0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic mode_valid(input logic [MODE_W-1:0] mode);
        return (mode == CRC_MODE_8) || (mode == CRC_MODE_CCITT) || (mode == CRC_MODE_16);
    endfunction

    function automatic logic [CRC_W-1:0] crc_init(input logic [MODE_W-1:0] mode);
        case (mode)
            CRC_MODE_CCITT: return INIT_CCITT;
            CRC_MODE_16:    return INIT_16;
            default:        return INIT_8;
        endcase
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte MSB-first CRC update for the selected mode; CRC-8 lives in the low
// byte of the 16-bit register and the high byte is forced to zero.
module crc_byte_step
    import crc_pkg::*;
(
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [CRC_W-1:0]  crc_c_o
);

    logic [BYTE_W-1:0] c8;
    logic [CRC_W-1:0]  c16;
    logic [CRC_W-1:0]  poly16;

    always_comb begin
        c8     = crc_i[BYTE_W-1:0] ^ byte_i;
        c16    = crc_i ^ {byte_i, BYTE_W'(0)};
        poly16 = (mode_i == CRC_MODE_16) ? POLY_16 : POLY_CCITT;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            c8  = c8[BYTE_W-1] ? ((c8 << 1) ^ POLY_8) : (c8 << 1);
            c16 = c16[CRC_W-1] ? ((c16 << 1) ^ poly16) : (c16 << 1);
        end
        crc_c_o = (mode_i == CRC_MODE_8) ? {BYTE_W'(0), c8} : c16;
    end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC-8/CRC-16 over data_len big-endian bytes of 32-bit words,
// delivering the result with a one-cycle en_data_crc strobe.
module crc_engine
    import crc_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mst_begin,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [MODE_W-1:0] crc_mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [CRC_W-1:0]  crc_data,
    output logic              en_data_crc,
    output logic              error,
    output logic              busy
);

    localparam int unsigned STEPS = DATA_W / BYTE_W;

    state_e              state_q, state_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [LEN_W-1:0]    bytes_left_q, bytes_left_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [CRC_W-1:0]    crc_data_q, crc_data_d;
    logic                en_q, en_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;

    logic [CRC_W-1:0]    chain [STEPS+1];
    logic [1:0]          last_idx;
    logic [CRC_W-1:0]    crc_fold;

    assign chain[0] = crc_q;

    // Byte k of the word is folded by step k; step 0 sees the MSB byte.
    for (genvar k = 0; k < int'(STEPS); k++) begin : g_step
        crc_byte_step u_step (
            .crc_i   (chain[k]),
            .byte_i  (data_in[DATA_W-1-BYTE_W*k -: BYTE_W]),
            .mode_i  (mode_q),
            .crc_c_o (chain[k+1])
        );
    end

    // Tap the chain after min(bytes_left, 4) steps; bytes_left is never 0 in RUN.
    always_comb begin
        if (bytes_left_q >= LEN_W'(4)) begin
            last_idx = 2'd3;
        end else begin
            last_idx = bytes_left_q[1:0] - 2'd1;
        end
        crc_fold = chain[3'(last_idx) + 3'd1];
    end

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        bytes_left_d = bytes_left_q;
        mode_d       = mode_q;
        crc_data_d   = crc_data_q;
        en_d         = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mst_begin) begin
                    if (!mode_valid(crc_mode)) begin
                        error_d = 1'b1;
                    end else if (data_len == LEN_W'(0)) begin
                        crc_data_d = crc_init(crc_mode);
                        en_d       = 1'b1;
                    end else begin
                        crc_d        = crc_init(crc_mode);
                        bytes_left_d = data_len;
                        mode_d       = crc_mode;
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (data_valid) begin
                    crc_d = crc_fold;
                    if (bytes_left_q <= LEN_W'(4)) begin
                        crc_data_d = crc_fold;
                        en_d       = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        bytes_left_d = bytes_left_q - LEN_W'(4);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            crc_q        <= '0;
            bytes_left_q <= '0;
            mode_q       <= CRC_MODE_8;
            crc_data_q   <= '0;
            en_q         <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            bytes_left_q <= bytes_left_d;
            mode_q       <= mode_d;
            crc_data_q   <= crc_data_d;
            en_q         <= en_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    assign data_ready  = busy_q;
    assign busy        = busy_q;
    assign crc_data    = crc_data_q;
    assign en_data_crc = en_q;
    assign error       = error_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed vector bench for crc_engine: table of messages plus hand-written
// reset, back-to-back and idle-valid sequences.
module tb_crc_engine;

    logic        clk;
    logic        rst_n;
    logic        mst_begin;
    logic [15:0] data_len;
    logic [2:0]  crc_mode;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] crc_data;
    logic        en_data_crc;
    logic        error;
    logic        busy;

    int n_vec;
    int n_bad;
    logic [15:0] exp_hold;

    crc_engine #(.DATA_W(32), .LEN_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mst_begin   (mst_begin),
        .data_len    (data_len),
        .crc_mode    (crc_mode),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .crc_data    (crc_data),
        .en_data_crc (en_data_crc),
        .error       (error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          gap;
        bit          poke;
        bit          err;
        logic [15:0] crc;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference over the leading nbytes of one word.
    function automatic logic [15:0] crc_ref(input logic [2:0] mode, input logic [31:0] word,
                                            input int nbytes);
        logic [15:0] c;
        logic [15:0] poly;
        logic        fb;
        int          top;
        c    = (mode == 3'b001) ? 16'hFFFF : 16'h0000;
        poly = (mode == 3'b001) ? 16'h1021 : (mode == 3'b010) ? 16'h8005 : 16'h0007;
        top  = (mode == 3'b000) ? 7 : 15;
        for (int b = 31; b >= 32 - 8 * nbytes; b--) begin
            fb = c[top] ^ word[b];
            c  = c << 1;
            if (fb) c = c ^ poly;
        end
        if (mode == 3'b000) c[15:8] = 8'h00;
        return c;
    endfunction

    task automatic run_msg(input string name, input logic [2:0] mode, input logic [15:0] len,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input int gap, input bit poke, input bit err,
                           input logic [15:0] exp_crc, input bit tail);
        logic [31:0] w [3];
        int nwords;
        w[0] = w0; w[1] = w1; w[2] = w2;
        nwords = (int'(len) + 3) / 4;

        mst_begin = 1'b1;
        data_len  = len;
        crc_mode  = mode;
        tick();
        mst_begin = 1'b0;

        if (err) begin
            chk({name, ".error"}, 32'(error), 32'd1);
            chk({name, ".err_busy"}, 32'(busy), 32'd0);
            chk({name, ".err_en"}, 32'(en_data_crc), 32'd0);
            chk({name, ".err_crc_held"}, 32'(crc_data), 32'(exp_hold));
        end else if (len == 16'd0) begin
            chk({name, ".zl_en"}, 32'(en_data_crc), 32'd1);
            chk({name, ".zl_crc"}, 32'(crc_data), 32'(exp_crc));
            chk({name, ".zl_ready"}, 32'(data_ready), 32'd0);
            exp_hold = exp_crc;
        end else begin
            chk({name, ".start_busy"}, 32'(busy), 32'd1);
            chk({name, ".start_ready"}, 32'(data_ready), 32'd1);
            chk({name, ".start_crc_held"}, 32'(crc_data), 32'(exp_hold));
            for (int i = 0; i < nwords; i++) begin
                if (i > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        data_valid = 1'b0;
                        data_in    = 32'hDEAD_BEEF;
                        mst_begin  = poke;
                        data_len   = 16'd4;
                        crc_mode   = 3'b000;
                        tick();
                        chk({name, ".gap_busy"}, 32'(busy), 32'd1);
                        chk({name, ".gap_en"}, 32'(en_data_crc), 32'd0);
                    end
                    mst_begin = 1'b0;
                end
                data_valid = 1'b1;
                data_in    = w[i];
                tick();
                data_valid = 1'b0;
                if (i < nwords - 1) begin
                    chk({name, ".mid_en"}, 32'(en_data_crc), 32'd0);
                    chk({name, ".mid_busy"}, 32'(busy), 32'd1);
                end else begin
                    chk({name, ".done_en"}, 32'(en_data_crc), 32'd1);
                    chk({name, ".done_crc"}, 32'(crc_data), 32'(exp_crc));
                    chk({name, ".done_busy"}, 32'(busy), 32'd0);
                    chk({name, ".done_ready"}, 32'(data_ready), 32'd0);
                end
            end
            exp_hold = exp_crc;
        end

        if (tail) begin
            tick();
            chk({name, ".strobe_drop_en"}, 32'(en_data_crc), 32'd0);
            chk({name, ".strobe_drop_err"}, 32'(error), 32'd0);
            chk({name, ".hold_crc"}, 32'(crc_data), 32'(exp_hold));
        end
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        exp_hold   = 16'h0000;
        rst_n      = 1'b0;
        mst_begin  = 1'b0;
        data_len   = 16'd0;
        crc_mode   = 3'b000;
        data_in    = 32'h0;
        data_valid = 1'b0;

        //          mode    len    w0            w1            w2            gap poke err crc
        vecs[0]  = '{3'b001, 16'd9, 32'h31323334, 32'h35363738, 32'h39AABBCC, 0, 1'b0, 1'b0, 16'h29B1};
        vecs[1]  = '{3'b010, 16'd9, 32'h31323334, 32'h35363738, 32'h39AABBCC, 0, 1'b0, 1'b0, 16'hFEE8};
        vecs[2]  = '{3'b000, 16'd9, 32'h31323334, 32'h35363738, 32'h39AABBCC, 0, 1'b0, 1'b0, 16'h00F4};
        vecs[3]  = '{3'b001, 16'd9, 32'h31323334, 32'h35363738, 32'h39AABBCC, 3, 1'b0, 1'b0, 16'h29B1};
        vecs[4]  = '{3'b001, 16'd9, 32'h31323334, 32'h35363738, 32'h39AABBCC, 2, 1'b1, 1'b0, 16'h29B1};
        vecs[5]  = '{3'b000, 16'd1, 32'h31FFFFFF, 32'h0,        32'h0,        0, 1'b0, 1'b0, 16'h0097};
        vecs[6]  = '{3'b001, 16'd0, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b0, 16'hFFFF};
        vecs[7]  = '{3'b101, 16'd9, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b1, 16'h0000};
        vecs[8]  = '{3'b010, 16'd0, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{3'b011, 16'd0, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b1, 16'h0000};
        vecs[10] = '{3'b111, 16'd4, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b1, 16'h0000};
        vecs[11] = '{3'b000, 16'd0, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b0, 16'h0000};

        repeat (3) tick();
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.ready", 32'(data_ready), 32'd0);
        chk("reset.en", 32'(en_data_crc), 32'd0);
        chk("reset.error", 32'(error), 32'd0);
        chk("reset.crc", 32'(crc_data), 32'h0);
        rst_n = 1'b1;
        tick();

        // data_valid while idle must not start anything
        data_valid = 1'b1;
        data_in    = 32'h1234_5678;
        repeat (2) begin
            tick();
            chk("idle_valid.ready", 32'(data_ready), 32'd0);
            chk("idle_valid.en", 32'(en_data_crc), 32'd0);
        end
        data_valid = 1'b0;

        for (int v = 0; v < NVEC; v++) begin
            run_msg($sformatf("vec%0d", v), vecs[v].mode, vecs[v].len, vecs[v].w0, vecs[v].w1,
                    vecs[v].w2, vecs[v].gap, vecs[v].poke, vecs[v].err, vecs[v].crc, 1'b1);
        end

        // Reset after the second word of a 9-byte message, then a clean restart.
        mst_begin = 1'b1;
        data_len  = 16'd9;
        crc_mode  = 3'b001;
        tick();
        mst_begin  = 1'b0;
        data_valid = 1'b1;
        data_in    = 32'h31323334;
        tick();
        data_in    = 32'h35363738;
        tick();
        data_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("midreset.busy", 32'(busy), 32'd0);
        chk("midreset.ready", 32'(data_ready), 32'd0);
        chk("midreset.en", 32'(en_data_crc), 32'd0);
        chk("midreset.crc", 32'(crc_data), 32'h0);
        tick();
        rst_n    = 1'b1;
        exp_hold = 16'h0000;
        tick();
        run_msg("restart", 3'b001, 16'd9, 32'h31323334, 32'h35363738, 32'h39AABBCC,
                0, 1'b0, 1'b0, 16'h29B1, 1'b1);

        // Back-to-back: second start issued in the first message's strobe cycle.
        run_msg("b2b_first", 3'b001, 16'd9, 32'h31323334, 32'h35363738, 32'h39AABBCC,
                0, 1'b0, 1'b0, 16'h29B1, 1'b0);
        run_msg("b2b_second", 3'b001, 16'd4, 32'h31323334, 32'h0, 32'h0,
                0, 1'b0, 1'b0, crc_ref(3'b001, 32'h31323334, 4), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
